// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared sign-magnitude fixed-point constants for the adder/subtractor family
package fixed_point_pkg;
  localparam int FP_BITSIZE = 16;
  localparam int FP_FRAC = 8;
  localparam int FP_SIGN_BIT = FP_BITSIZE - 1;
  localparam logic [FP_BITSIZE-2:0] FP_MAX_MAG = '1;
  localparam logic [FP_BITSIZE-1:0] FP_ZERO = '0;
endpackage

// File: rtl/fixed_point_sub_pipe_if.sv
// fixed_point_sub_pipe_if: operand/result streams with valid/ready handshakes
//   in_valid/in_ready/in_a/in_b : operand pair stream (A - B)
//   out_valid/out_ready/out_c/out_ovf : result stream, ovf flags saturation
interface fixed_point_sub_pipe_if #(parameter int BITSIZE = fixed_point_pkg::FP_BITSIZE);
  logic in_valid;
  logic in_ready;
  logic [BITSIZE-1:0] in_a;
  logic [BITSIZE-1:0] in_b;
  logic out_valid;
  logic out_ready;
  logic [BITSIZE-1:0] out_c;
  logic out_ovf;
  modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_c, out_ovf);
  modport slave (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_c, out_ovf);
endinterface

// File: rtl/sm_addsub_core.sv
// sm_addsub_core: combinational sign-magnitude add of pre-split operands with saturation
//   sa: sign of first operand; ma/mb: magnitudes; same: effective signs equal; a_ge: ma >= mb
//   sign/mag/ovf: result sign, magnitude, saturation flag
module sm_addsub_core #(parameter int MAG_W = fixed_point_pkg::FP_BITSIZE - 1) (
  input  logic sa,
  input  logic [MAG_W-1:0] ma,
  input  logic [MAG_W-1:0] mb,
  input  logic same,
  input  logic a_ge,
  output logic sign,
  output logic [MAG_W-1:0] mag,
  output logic ovf
);
  logic [MAG_W:0] sum;
  logic [MAG_W-1:0] diff;
  logic raw_sign;
  assign sum = {1'b0, ma} + {1'b0, mb};
  assign diff = a_ge ? ma - mb : mb - ma;
  assign ovf = same && sum[MAG_W];
  assign mag = same ? (sum[MAG_W] ? '1 : sum[MAG_W-1:0]) : diff;
  // signs differ here, so the second operand's sign is simply ~sa
  assign raw_sign = (same || a_ge) ? sa : ~sa;
  // canonical +0: a zero magnitude never carries a negative sign
  assign sign = (|mag) && raw_sign;
endmodule

// File: rtl/fixed_point_sub_pipe.sv
// fixed_point_sub_pipe: two-stage pipelined saturating sign-magnitude subtractor C = A - B
//   clk/rst: clock, async active-high reset
//   bus: slave side of fixed_point_sub_pipe_if (operand stream in, result stream out)
module fixed_point_sub_pipe import fixed_point_pkg::*; #(
  parameter int BITSIZE = FP_BITSIZE,
  parameter int FRAC = FP_FRAC
) (
  input logic clk,
  input logic rst,
  fixed_point_sub_pipe_if.slave bus
);
  localparam int M = BITSIZE - 1;
  if (FRAC < 0 || FRAC > M) begin : g_frac_chk
    $error("FRAC must fit inside the magnitude field");
  end
  logic s1_valid, sa, same, a_ge;
  logic [M-1:0] ma, mb;
  logic sb_in, s2_free, s1_adv, in_xfer;
  logic sign, ovf;
  logic [M-1:0] mag;
  assign s2_free = !bus.out_valid || bus.out_ready;
  assign s1_adv = s1_valid && s2_free;
  assign bus.in_ready = !rst && (!s1_valid || s1_adv);
  assign in_xfer = bus.in_valid && bus.in_ready;
  // subtraction is addition of B with its sign flipped
  assign sb_in = ~bus.in_b[M];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      sa <= 1'b0;
      ma <= '0;
      mb <= '0;
      same <= 1'b0;
      a_ge <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      sa <= bus.in_a[M];
      ma <= bus.in_a[M-1:0];
      mb <= bus.in_b[M-1:0];
      same <= bus.in_a[M] == sb_in;
      a_ge <= bus.in_a[M-1:0] >= bus.in_b[M-1:0];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end
  sm_addsub_core #(.MAG_W(M)) u_core (
    .sa(sa), .ma(ma), .mb(mb), .same(same), .a_ge(a_ge),
    .sign(sign), .mag(mag), .ovf(ovf)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_c <= '0;
      bus.out_ovf <= 1'b0;
    end else if (s1_adv) begin
      bus.out_valid <= 1'b1;
      bus.out_c <= {sign, mag};
      bus.out_ovf <= ovf;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fixed_point_sub_pipe.sv
// tb_fixed_point_sub_pipe: directed self-checking bench for fixed_point_sub_pipe
module tb_fixed_point_sub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  fixed_point_sub_pipe_if #(.BITSIZE(16)) bus ();
  fixed_point_sub_pipe #(.BITSIZE(16), .FRAC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic o);
    @(negedge clk);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_c"}, 32'(bus.out_c), 32'(c));
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(o));
  endtask
  logic [15:0] sa_v [5] = '{16'h0300, 16'h0100, 16'h8100, 16'h0100, 16'h0100};
  logic [15:0] sb_v [5] = '{16'h0100, 16'h0300, 16'h0200, 16'h8200, 16'h0100};
  logic [15:0] sc_v [5] = '{16'h0200, 16'h8200, 16'h8300, 16'h0300, 16'h0000};
  initial begin
    int idx, k, first, seen;
    logic acc;
    logic [15:0] held;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_c", 32'(bus.out_c), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    run_vec("sub_pos", 16'h0300, 16'h0100, 16'h0200, 1'b0);
    run_vec("sub_neg", 16'h0100, 16'h0300, 16'h8200, 1'b0);
    run_vec("neg_a", 16'h8100, 16'h0200, 16'h8300, 1'b0);
    run_vec("neg_b", 16'h0100, 16'h8200, 16'h0300, 1'b0);
    run_vec("zero", 16'h0100, 16'h0100, 16'h0000, 1'b0);
    run_vec("negzero", 16'h8000, 16'h0000, 16'h0000, 1'b0);
    run_vec("sat_pos", 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1);
    run_vec("sat_neg", 16'hC000, 16'h4000, 16'hFFFF, 1'b1);
    run_vec("near_sat", 16'h4000, 16'hBFFF, 16'h7FFF, 1'b0);
    idx = 0;
    k = 0;
    first = -1;
    held = '0;
    for (int c = 0; c < 30 && k < 5; c++) begin
      @(negedge clk);
      bus.out_ready = (c >= 4);
      bus.in_valid = (idx < 5);
      if (idx < 5) begin
        bus.in_a = sa_v[idx];
        bus.in_b = sb_v[idx];
      end
      #1;
      if (c == 2) begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_accepts", 32'(idx), 32'd2);
        held = bus.out_c;
      end
      if (c == 3) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", 32'(bus.out_c), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_c", 32'(bus.out_c), 32'(sc_v[k]));
        if (k == 0) first = c;
        else chk("stream_rate", 32'(c), 32'(first + k));
        k++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    chk("stream_count", 32'(k), 32'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_a = 16'h7FFF;
    bus.in_b = 16'hFFFF;
    bus.in_valid = 1'b1;
    #1 chk("fill0_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_a = 16'h0300;
    bus.in_b = 16'h0100;
    #1 chk("fill1_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_c", 32'(bus.out_c), 32'h7FFF);
    chk("full_ovf", 32'(bus.out_ovf), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_c", 32'(bus.out_c), 32'd0);
    chk("arst_ovf", 32'(bus.out_ovf), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("no_stale", 32'(seen), 32'd0);
    run_vec("post_rst", 16'h0300, 16'h0100, 16'h0200, 1'b0);
    run_vec("post_rst_sat", 16'hC000, 16'h4000, 16'hFFFF, 1'b1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
